// File: rtl/alu_pkg.sv
// Shared ALU definitions: aluop encodings, request op codes, issue FSM states
// and the request-op to aluop mapping.
package alu_pkg;

  localparam logic [2:0] ALUOP_SUB  = 3'b000;
  localparam logic [2:0] ALUOP_NEG  = 3'b001;
  localparam logic [2:0] ALUOP_INC  = 3'b010;
  localparam logic [2:0] ALUOP_NOP  = 3'b011;
  localparam logic [2:0] ALUOP_ADD  = 3'b100;
  localparam logic [2:0] ALUOP_PASS = 3'b111;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_INC = 3'b010,
    OP_NEG = 3'b011,
    OP_MOV = 3'b100,
    OP_BRZ = 3'b101,
    OP_BRN = 3'b110,
    OP_ILL = 3'b111
  } req_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_CAPT,
    S_RESP
  } state_e;

  function automatic logic is_alu_op(req_op_e op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_INC) ||
           (op == OP_NEG) || (op == OP_MOV);
  endfunction

  // Non-ALU ops map to NOP so the ALU flags are never disturbed.
  function automatic logic [2:0] op_to_aluop(req_op_e op);
    case (op)
      OP_ADD:  return ALUOP_ADD;
      OP_SUB:  return ALUOP_SUB;
      OP_INC:  return ALUOP_INC;
      OP_NEG:  return ALUOP_NEG;
      OP_MOV:  return ALUOP_PASS;
      default: return ALUOP_NOP;
    endcase
  endfunction

endpackage

// File: rtl/alu_issue_ctrl.sv
// Request sequencer for the one-cycle-latency ALU: issues an op, captures the
// result and flags, and resolves BRZ/BRN from the held flags of the last ALU op.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_req_valid,
  output logic             out_req_ready,
  input  logic [2:0]       in_req_op,
  input  logic [WIDTH-1:0] in_req_a,
  input  logic [WIDTH-1:0] in_req_b,
  output logic [WIDTH-1:0] out_alu_a,
  output logic [WIDTH-1:0] out_alu_b,
  output logic [2:0]       out_alu_aluop,
  input  logic [WIDTH-1:0] in_alu_result,
  input  logic             in_alu_zero,
  input  logic             in_alu_neg,
  output logic             out_rsp_valid,
  input  logic             in_rsp_ready,
  output logic [WIDTH-1:0] out_rsp_result,
  output logic             out_rsp_zero,
  output logic             out_rsp_neg,
  output logic             out_rsp_taken,
  output logic             out_rsp_err
);

  state_e           r_state, w_state_nxt;
  req_op_e          r_op;
  req_op_e          w_req_op;
  logic             w_accept;
  logic             r_held_zero, r_held_neg;
  logic [WIDTH-1:0] r_alu_a, r_alu_b, r_rsp_result;
  logic             r_rsp_zero, r_rsp_neg, r_rsp_taken, r_rsp_err;

  assign w_req_op = req_op_e'(in_req_op);
  assign w_accept = in_req_valid && out_req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    out_req_ready = 1'b0;
    out_rsp_valid = 1'b0;
    out_alu_aluop = ALUOP_NOP;
    case (r_state)
      S_IDLE: begin
        out_req_ready = 1'b1;
        if (in_req_valid) w_state_nxt = is_alu_op(w_req_op) ? S_ISSUE : S_RESP;
      end
      S_ISSUE: begin
        out_alu_aluop = op_to_aluop(r_op);
        w_state_nxt   = S_CAPT;
      end
      S_CAPT: w_state_nxt = S_RESP;
      S_RESP: begin
        out_rsp_valid = 1'b1;
        if (in_rsp_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op         <= OP_ADD;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_held_zero  <= 1'b0;
      r_held_neg   <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_zero   <= 1'b0;
      r_rsp_neg    <= 1'b0;
      r_rsp_taken  <= 1'b0;
      r_rsp_err    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op <= w_req_op;
        if (is_alu_op(w_req_op)) begin
          r_alu_a <= in_req_a;
          r_alu_b <= in_req_b;
        end else begin
          // Branch / illegal: response is ready straight from the held flags.
          r_rsp_result <= '0;
          r_rsp_zero   <= r_held_zero;
          r_rsp_neg    <= r_held_neg;
          r_rsp_taken  <= (w_req_op == OP_BRZ) ? r_held_zero :
                          (w_req_op == OP_BRN) ? r_held_neg  : 1'b0;
          r_rsp_err    <= (w_req_op == OP_ILL);
        end
      end
      if (r_state == S_CAPT) begin
        r_rsp_result <= in_alu_result;
        r_rsp_zero   <= in_alu_zero;
        r_rsp_neg    <= in_alu_neg;
        r_rsp_taken  <= 1'b0;
        r_rsp_err    <= 1'b0;
        r_held_zero  <= in_alu_zero;
        r_held_neg   <= in_alu_neg;
      end
      if (r_state == S_RESP && in_rsp_ready) begin
        r_rsp_result <= '0;
        r_rsp_zero   <= 1'b0;
        r_rsp_neg    <= 1'b0;
        r_rsp_taken  <= 1'b0;
        r_rsp_err    <= 1'b0;
      end
    end
  end

  assign out_alu_a      = r_alu_a;
  assign out_alu_b      = r_alu_b;
  assign out_rsp_result = r_rsp_result;
  assign out_rsp_zero   = r_rsp_zero;
  assign out_rsp_neg    = r_rsp_neg;
  assign out_rsp_taken  = r_rsp_taken;
  assign out_rsp_err    = r_rsp_err;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a registered ALU model in the loop.
module tb_alu_issue_ctrl;

  localparam int W = 32;
  localparam logic [2:0] NOP = 3'b011;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_req_valid;
  logic         out_req_ready;
  logic [2:0]   in_req_op;
  logic [W-1:0] in_req_a, in_req_b;
  logic [W-1:0] out_alu_a, out_alu_b;
  logic [2:0]   out_alu_aluop;
  logic [W-1:0] in_alu_result;
  logic         in_alu_zero, in_alu_neg;
  logic         out_rsp_valid;
  logic         in_rsp_ready;
  logic [W-1:0] out_rsp_result;
  logic         out_rsp_zero, out_rsp_neg, out_rsp_taken, out_rsp_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_req_valid(in_req_valid), .out_req_ready(out_req_ready),
    .in_req_op(in_req_op), .in_req_a(in_req_a), .in_req_b(in_req_b),
    .out_alu_a(out_alu_a), .out_alu_b(out_alu_b), .out_alu_aluop(out_alu_aluop),
    .in_alu_result(in_alu_result), .in_alu_zero(in_alu_zero), .in_alu_neg(in_alu_neg),
    .out_rsp_valid(out_rsp_valid), .in_rsp_ready(in_rsp_ready),
    .out_rsp_result(out_rsp_result), .out_rsp_zero(out_rsp_zero),
    .out_rsp_neg(out_rsp_neg), .out_rsp_taken(out_rsp_taken), .out_rsp_err(out_rsp_err)
  );

  // Registered ALU model: samples aluop/operands at each edge, NOP holds state.
  logic [W-1:0] m_res = '0;
  always @(posedge clk) begin
    logic [W-1:0] t;
    t = m_res;
    case (out_alu_aluop)
      3'b100:  t = out_alu_b + out_alu_a;
      3'b000:  t = out_alu_b - out_alu_a;
      3'b010:  t = out_alu_a + 1;
      3'b001:  t = -out_alu_a;
      3'b111:  t = out_alu_a;
      default: t = m_res;
    endcase
    m_res       <= t;
    in_alu_zero <= (t == '0);
    in_alu_neg  <= t[W-1];
  end
  assign in_alu_result = m_res;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a, b;
    logic [2:0]   aluop;
    logic [W-1:0] res;
    logic         z, n, t, e;
    int           lat;
  } vec_t;

  vec_t vecs[12];

  task automatic do_op(input vec_t v, input int idx);
    int lat, issued;
    logic [2:0] seen;
    string tag;
    tag = $sformatf("v%0d", idx);
    issued = 0;
    seen = NOP;
    in_rsp_ready = 1'b1;
    @(negedge clk);
    chk({tag, " req_ready"}, W'(out_req_ready), W'(1));
    in_req_valid = 1'b1; in_req_op = v.op; in_req_a = v.a; in_req_b = v.b;
    @(posedge clk); #1;
    in_req_valid = 1'b0;
    lat = 1;
    while (!out_rsp_valid && lat < 20) begin
      if (out_alu_aluop != NOP) begin issued++; seen = out_alu_aluop; end
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " latency"}, W'(lat), W'(v.lat));
    chk({tag, " issue_cycles"}, W'(issued), W'((v.lat == 3) ? 1 : 0));
    chk({tag, " aluop"}, W'(seen), W'(v.aluop));
    chk({tag, " aluop_resp"}, W'(out_alu_aluop), W'(NOP));
    chk({tag, " result"}, out_rsp_result, v.res);
    chk({tag, " zero"}, W'(out_rsp_zero), W'(v.z));
    chk({tag, " neg"}, W'(out_rsp_neg), W'(v.n));
    chk({tag, " taken"}, W'(out_rsp_taken), W'(v.t));
    chk({tag, " err"}, W'(out_rsp_err), W'(v.e));
    @(posedge clk); #1;
    chk({tag, " valid_drop"}, W'(out_rsp_valid), W'(0));
    chk({tag, " ready_back"}, W'(out_req_ready), W'(1));
  endtask

  initial begin
    logic [W-1:0] h_res;
    logic [3:0]   h_flags;
    int           n;
    vec_t         v;
    //           op      a             b     aluop   res           z     n     t     e     lat
    vecs[0]  = '{3'b001, 32'd5,        32'd5, 3'b000, 32'd0,        1'b1, 1'b0, 1'b0, 1'b0, 3};
    vecs[1]  = '{3'b101, 32'd0,        32'd0, NOP,    32'd0,        1'b1, 1'b0, 1'b1, 1'b0, 1};
    vecs[2]  = '{3'b000, 32'd3,        32'd4, 3'b100, 32'd7,        1'b0, 1'b0, 1'b0, 1'b0, 3};
    vecs[3]  = '{3'b101, 32'd0,        32'd0, NOP,    32'd0,        1'b0, 1'b0, 1'b0, 1'b0, 1};
    vecs[4]  = '{3'b000, 32'hFFFFFFF6, 32'd3, 3'b100, 32'hFFFFFFF9, 1'b0, 1'b1, 1'b0, 1'b0, 3};
    vecs[5]  = '{3'b110, 32'd0,        32'd0, NOP,    32'd0,        1'b0, 1'b1, 1'b1, 1'b0, 1};
    vecs[6]  = '{3'b011, 32'd1,        32'd0, 3'b001, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 1'b0, 3};
    vecs[7]  = '{3'b010, 32'hFFFFFFFF, 32'd0, 3'b010, 32'd0,        1'b1, 1'b0, 1'b0, 1'b0, 3};
    vecs[8]  = '{3'b111, 32'd9,        32'd9, NOP,    32'd0,        1'b1, 1'b0, 1'b0, 1'b1, 1};
    vecs[9]  = '{3'b101, 32'd0,        32'd0, NOP,    32'd0,        1'b1, 1'b0, 1'b1, 1'b0, 1};
    vecs[10] = '{3'b100, 32'h1234,     32'd0, 3'b111, 32'h1234,     1'b0, 1'b0, 1'b0, 1'b0, 3};
    vecs[11] = '{3'b110, 32'd0,        32'd0, NOP,    32'd0,        1'b0, 1'b0, 1'b0, 1'b0, 1};

    rst_n = 1'b0; in_req_valid = 1'b0; in_req_op = '0; in_req_a = '0; in_req_b = '0;
    in_rsp_ready = 1'b1;
    #12;
    chk("rst aluop", W'(out_alu_aluop), W'(NOP));
    chk("rst rsp_valid", W'(out_rsp_valid), W'(0));
    chk("rst req_ready", W'(out_req_ready), W'(1));
    chk("rst alu_a", out_alu_a, '0);
    chk("rst rsp_result", out_rsp_result, '0);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 12; i++) do_op(vecs[i], i);

    // Back-pressure: ADD held in RESP for 5 cycles while a MOV waits.
    in_rsp_ready = 1'b0;
    @(negedge clk);
    in_req_valid = 1'b1; in_req_op = 3'b000; in_req_a = 32'd10; in_req_b = 32'd20;
    @(posedge clk); #1;
    in_req_op = 3'b100; in_req_a = 32'h55; in_req_b = 32'd0;
    n = 0;
    while (!out_rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
    chk("bp reached_resp", W'(out_rsp_valid), W'(1));
    h_res = out_rsp_result;
    h_flags = {out_rsp_zero, out_rsp_neg, out_rsp_taken, out_rsp_err};
    chk("bp result", h_res, 32'd30);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk($sformatf("bp%0d valid", c), W'(out_rsp_valid), W'(1));
      chk($sformatf("bp%0d req_ready", c), W'(out_req_ready), W'(0));
      chk($sformatf("bp%0d result", c), out_rsp_result, h_res);
      chk($sformatf("bp%0d flags", c), W'({out_rsp_zero, out_rsp_neg, out_rsp_taken, out_rsp_err}), W'(h_flags));
    end
    @(negedge clk); in_rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp exit valid", W'(out_rsp_valid), W'(0));
    chk("bp exit req_ready", W'(out_req_ready), W'(1));
    @(posedge clk); #1;
    in_req_valid = 1'b0;
    chk("bp accept aluop", W'(out_alu_aluop), W'(3'b111));
    chk("bp accept req_ready", W'(out_req_ready), W'(0));
    n = 0;
    while (!out_rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
    chk("bp mov latency", W'(n), W'(2));
    chk("bp mov result", out_rsp_result, 32'h55);
    @(posedge clk); #1;

    // Set held zero, then reset during ISSUE of a SUB.
    v = vecs[0];
    do_op(v, 20);
    @(negedge clk);
    in_req_valid = 1'b1; in_req_op = 3'b001; in_req_a = 32'd1; in_req_b = 32'd1;
    @(posedge clk); #1;
    in_req_valid = 1'b0;
    chk("mid issue aluop", W'(out_alu_aluop), W'(3'b000));
    #2 rst_n = 1'b0;
    #1;
    chk("async rst aluop", W'(out_alu_aluop), W'(NOP));
    chk("async rst valid", W'(out_rsp_valid), W'(0));
    chk("async rst req_ready", W'(out_req_ready), W'(1));
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    n = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (out_rsp_valid) n++;
    end
    chk("dropped op no rsp", W'(n), W'(0));
    // Held flags cleared by reset: BRZ now not taken.
    v = vecs[3];
    do_op(v, 21);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Request-side sequencer for the datapath ALU. Accepts one operation per valid/ready handshake and drives the ALU's operand and aluop inputs.
- Waits out the ALU's one-cycle registered latency, then captures the result and zero/neg flags and returns them on a valid/ready response channel.
- Resolves conditional branches (BRZ/BRN) from a held copy of the flags of the last completed arithmetic op, without touching the ALU.

Parameters:
- WIDTH, 32, operand/result width; must match the ALU datapath.

Ports:
- clk  input  1  rising-edge clock, shared with the ALU
- rst_n  input  1  reset, asynchronous assert, active-low
- in_req_valid  input  1  request present
- out_req_ready  output  1  block can accept a request
- in_req_op  input  3  operation code (see package)
- in_req_a  input  WIDTH  operand A
- in_req_b  input  WIDTH  operand B
- out_alu_a  output  WIDTH  to ALU in_a
- out_alu_b  output  WIDTH  to ALU in_b
- out_alu_aluop  output  3  to ALU in_ctrl_aluop
- in_alu_result  input  WIDTH  from ALU out_result
- in_alu_zero  input  1  from ALU out_zero
- in_alu_neg  input  1  from ALU out_neg
- out_rsp_valid  output  1  response present
- in_rsp_ready  input  1  consumer accepts response
- out_rsp_result  output  WIDTH  ALU result (0 for branches and errors)
- out_rsp_zero  output  1  held zero flag after this op
- out_rsp_neg  output  1  held neg flag after this op
- out_rsp_taken  output  1  branch taken (0 for non-branch ops)
- out_rsp_err  output  1  illegal op code

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values:
  - State is IDLE.
  - out_alu_aluop = 3'b011 (ALU NOP).
  - out_alu_a, out_alu_b, out_rsp_result = 0.
  - All out_rsp_* flags and out_rsp_valid = 0.
  - Held flags = 0.
- out_req_ready = 1 only in IDLE. A request is accepted on a clock edge where in_req_valid && out_req_ready; operands and op are registered on that edge.
- FSM states: IDLE, ISSUE, CAPT, RESP.
  - IDLE, accept an ALU op (ADD/SUB/INC/NEG/MOV) -> ISSUE.
  - IDLE, accept BRZ/BRN/illegal -> RESP.
  - ISSUE: out_alu_aluop = mapped code for exactly one cycle; the ALU samples it at the end of this cycle. -> CAPT.
  - CAPT: ALU outputs are valid. Register in_alu_result, in_alu_zero and in_alu_neg into the response and the held flags. -> RESP.
  - RESP: out_rsp_valid = 1, and all response fields are held stable until in_rsp_ready. On in_rsp_valid && in_rsp_ready -> IDLE. A new request is accepted no earlier than the next cycle (no bypass).
- out_alu_aluop = 3'b011 in every state except ISSUE, so ALU flags never change outside issued ops.
- ALU op mapping to aluop:
  - ADD -> 100 (b+a)
  - SUB -> 000 (b-a)
  - INC -> 010 (a+1)
  - NEG -> 001 (-a)
  - MOV -> 111 (a)
- out_alu_a/out_alu_b carry the registered operands from ISSUE through CAPT and are otherwise held.
- Branches:
  - BRZ: taken = held zero. BRN: taken = held neg.
  - Branches do not issue to the ALU and do not modify the held flags.
  - out_rsp_zero/out_rsp_neg report the held flags.
- Illegal op (3'b111): out_rsp_err = 1, taken = 0, result = 0; held flags unchanged.
- Latency from accept edge to out_rsp_valid high: ALU ops 3 cycles; branch and illegal ops 1 cycle.
- Response fields are meaningful only while out_rsp_valid = 1 and are cleared on return to IDLE.
- Back-pressure: in_rsp_ready low holds RESP indefinitely, with outputs stable and out_req_ready = 0.
- rst_n low in any state immediately forces IDLE, aluop NOP, out_rsp_valid = 0, and held flags = 0. Any in-flight op is dropped and never responded to.
- Arithmetic is the ALU's; this block does not compute results or flags, it only registers them.

Decomposition:
- Shared package alu_pkg holds:
  - ALU aluop constants: ADD 100, INC 010, NEG 001, SUB 000, PASS 111, NOP 011.
  - Request op enum: ADD 000, SUB 001, INC 010, NEG 011, MOV 100, BRZ 101, BRN 110, ILL 111.
  - FSM state typedef.
- No sub-module; the op-to-aluop mapping is a package function.

Test Plan:
- Reset mid-ISSUE (SUB pending) -> aluop 011, out_rsp_valid 0, out_req_ready 1 asynchronously; no response ever appears.
- SUB a=5 b=5 (bench ALU model) -> aluop 000 for exactly one cycle, rsp_valid 3 cycles after accept, result 0, zero 1, neg 0; then BRZ -> 1 cycle later taken 1, err 0.
- ADD a=3 b=4 -> result 7, zero 0; then BRZ -> taken 0; then BRN with bench driving neg=1 on the prior op -> taken 1.
- INC a=0xFFFFFFFF -> result 0, zero 1; then MOV a=0x1234 -> result 0x1234, aluop 111 only in ISSUE.
- Hold in_rsp_ready low 5 cycles after ADD -> response fields stable, out_req_ready 0, a second in_req_valid is not accepted; accept occurs the cycle after RESP exits.
- Op 3'b111 -> err 1, taken 0, result 0, aluop stays 011 throughout, held flags unchanged (checked by a following BRZ).
